// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default baud divisor and the scheduler
// state encoding used by uart_tx_sched.
package uart_pkg;

    localparam int UART_BYTE_W   = 8;
    localparam int UART_BAUD_DIV = 2604;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        ARM  = 3'd2,
        WAIT = 3'd3,
        GAP  = 3'd4
    } sched_state_e;

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational rotate-priority picker: first set request scanning from rr_ptr
// upward with wrap at N; one-hot grant plus valid.
module rr_arb_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     gnt,
    output logic             vld
);

    logic [PTR_W:0] pos;

    // One extra bit on pos so the explicit wrap also works when N is not a power of 2.
    always_comb begin
        gnt = '0;
        vld = 1'b0;
        pos = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (pos >= (PTR_W+1)'(N)) begin
                pos = pos - (PTR_W+1)'(N);
            end
            if (!vld && req[pos[PTR_W-1:0]]) begin
                gnt[pos[PTR_W-1:0]] = 1'b1;
                vld                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-locked round-robin scheduler sharing one 8N1 UART transmitter between
// NUM_REQ byte streams. Define UART_TX_SCHED_GAP_EN to add an idle GAP after each packet.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MAX_PKT    = 16,
    parameter int GAP_CYCLES = UART_BAUD_DIV
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic                           trmt,
    output logic [UART_BYTE_W-1:0]         tx_data,
    input  logic                           tx_done
);

    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_PKT < 1 || MAX_PKT > 255 ||
        GAP_CYCLES < 1 || GAP_CYCLES > 65535) begin : g_bad_cfg
        $error("uart_tx_sched: parameter out of range");
    end

    sched_state_e             state_q, state_d;
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]         owner_q, owner_d;
    logic [7:0]               byte_cnt_q, byte_cnt_d;
    logic                     last_q, last_d;
    logic [NUM_REQ-1:0]       grant_q, grant_d;
    logic [NUM_REQ-1:0]       req_ack_q, req_ack_d;
    logic                     trmt_q, trmt_d;
    logic                     busy_q, busy_d;
    logic [UART_BYTE_W-1:0]   tx_data_q, tx_data_d;
`ifdef UART_TX_SCHED_GAP_EN
    logic [15:0]              gap_cnt_q, gap_cnt_d;
`endif

    logic [NUM_REQ-1:0]       pick_gnt;
    logic                     pick_vld;
    logic [PTR_W-1:0]         pick_idx;
    logic [PTR_W-1:0]         owner_nxt;
    logic [UART_BYTE_W-1:0]   sel_byte;
    logic                     end_pkt;

    rr_arb_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .gnt    (pick_gnt),
        .vld    (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                pick_idx = PTR_W'(i);
            end
            if (owner_q == PTR_W'(i)) begin
                sel_byte = req_data[UART_BYTE_W*i +: UART_BYTE_W];
            end
        end
    end

    assign owner_nxt = (owner_q == PTR_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
    assign end_pkt   = last_q || (byte_cnt_q == 8'(MAX_PKT));

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        byte_cnt_d = byte_cnt_q;
        last_d     = last_q;
        grant_d    = grant_q;
        req_ack_d  = '0;
        trmt_d     = 1'b0;
        tx_data_d  = tx_data_q;
`ifdef UART_TX_SCHED_GAP_EN
        gap_cnt_d  = gap_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_gnt;
                    owner_d = pick_idx;
                    state_d = SEND;
                end
            end
            SEND: begin
                // A stalled owner keeps the grant indefinitely.
                if (req[owner_q]) begin
                    trmt_d     = 1'b1;
                    req_ack_d  = grant_q;
                    tx_data_d  = sel_byte;
                    last_d     = req_last[owner_q];
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    state_d    = ARM;
                end
            end
            // tx_done is still high from the previous frame during this cycle.
            ARM: state_d = WAIT;
            WAIT: begin
                if (tx_done) begin
                    if (end_pkt) begin
                        rr_ptr_d   = owner_nxt;
                        grant_d    = '0;
                        byte_cnt_d = '0;
`ifdef UART_TX_SCHED_GAP_EN
                        gap_cnt_d  = '0;
                        state_d    = GAP;
`else
                        state_d    = IDLE;
`endif
                    end else begin
                        state_d = SEND;
                    end
                end
            end
`ifdef UART_TX_SCHED_GAP_EN
            GAP: begin
                if (gap_cnt_q == 16'(GAP_CYCLES-1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            byte_cnt_q <= '0;
            last_q     <= 1'b0;
            grant_q    <= '0;
            req_ack_q  <= '0;
            trmt_q     <= 1'b0;
            busy_q     <= 1'b0;
            tx_data_q  <= '0;
`ifdef UART_TX_SCHED_GAP_EN
            gap_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            byte_cnt_q <= byte_cnt_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            req_ack_q  <= req_ack_d;
            trmt_q     <= trmt_d;
            busy_q     <= busy_d;
            tx_data_q  <= tx_data_d;
`ifdef UART_TX_SCHED_GAP_EN
            gap_cnt_q  <= gap_cnt_d;
`endif
        end
    end

    assign grant   = grant_q;
    assign req_ack = req_ack_q;
    assign trmt    = trmt_q;
    assign busy    = busy_q;
    assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: requester byte queues, a tx_done model
// and a queue of expected (owner, byte) pairs checked at every trmt.
module tb_uart_tx_sched;
    import uart_pkg::*;

    localparam int NUM_REQ    = 4;
    localparam int MAX_PKT    = 4;
    localparam int GAP_CYCLES = 10;
`ifdef UART_TX_SCHED_GAP_EN
    localparam int EXP_GAP = 3 + GAP_CYCLES;
`else
    localparam int EXP_GAP = 3;
`endif

    typedef struct { logic [7:0] d; logic last; } rbyte_t;
    typedef struct { int id; logic [7:0] d; } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_last = '0;
    logic [NUM_REQ-1:0]   req_ack;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 trmt;
    logic [7:0]           tx_data;
    logic                 tx_done = 1'b1;

    rbyte_t rq [NUM_REQ][$];
    exp_t   exp_q [$];
    exp_t   e;
    logic [NUM_REQ-1:0] stall = '0;
    logic [NUM_REQ-1:0] prev_req;
    logic [NUM_REQ-1:0] one = 4'b0001;

    int cyc = 0, n_cmp = 0, n_err = 0, n_trmt = 0, tx_timer = 0;
    int last_done_rise = 0, req_rise_cyc = 0, last_trmt_cyc = 0, last_trmt_gap = 0;

    uart_tx_sched #(
        .NUM_REQ    (NUM_REQ),
        .MAX_PKT    (MAX_PKT),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .req_ack  (req_ack),
        .grant    (grant),
        .busy     (busy),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    // Monitor, transmitter model and requester drivers, all away from posedge.
    always @(negedge clk) begin
        cyc++;
        if (trmt && !rst) begin
            n_trmt++;
            last_trmt_gap = cyc - last_done_rise;
            last_trmt_cyc = cyc;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: trmt with data=%h grant=%b, no byte expected", tx_data, grant);
            end else begin
                e = exp_q.pop_front();
                if (tx_data !== e.d || grant !== (one << e.id) || req_ack !== grant) begin
                    n_err++;
                    $display("FAIL sb_byte: got data=%h grant=%b ack=%b, required data=%h grant=%b ack=%b",
                             tx_data, grant, req_ack, e.d, one << e.id, one << e.id);
                end
            end
        end
        if (rst) begin
            tx_timer = 0;
            tx_done  = 1'b1;
        end else if (trmt) begin
            tx_timer = 21;
        end else if (tx_timer > 0) begin
            tx_timer--;
            tx_done = (tx_timer == 0);
            if (tx_timer == 0) last_done_rise = cyc;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!rst && req_ack[k] && rq[k].size() > 0) rq[k].delete(0);
        end
        prev_req = req;
        for (int k = 0; k < NUM_REQ; k++) begin
            req[k] = (rq[k].size() > 0) && !stall[k];
            req_data[8*k +: 8] = (rq[k].size() > 0) ? rq[k][0].d : 8'h00;
            req_last[k]        = (rq[k].size() > 0) ? rq[k][0].last : 1'b0;
        end
        if (prev_req == '0 && req != '0) req_rise_cyc = cyc;
    end

    task automatic add_byte(input int id, input logic [7:0] d, input logic last);
        rbyte_t b;
        b.d = d;
        b.last = last;
        rq[id].push_back(b);
    endtask

    task automatic expect_byte(input int id, input logic [7:0] d);
        exp_t x;
        x.id = id;
        x.d  = d;
        exp_q.push_back(x);
    endtask

    function automatic int rq_total();
        int s = 0;
        for (int k = 0; k < NUM_REQ; k++) s += rq[k].size();
        return s;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || rq_total() != 0 || busy) && t < budget) begin
            @(posedge clk);
            t++;
        end
        n_cmp++;
        if (t >= budget) begin
            n_err++;
            $display("FAIL %s_drain: still busy after %0d cycles (exp left %0d), required idle", name, budget, exp_q.size());
        end
        @(posedge clk);
    endtask

    task automatic wait_trmt(input string name, input int n_from, input int budget);
        int t = 0;
        while (n_trmt == n_from && t < budget) begin
            @(posedge clk);
            t++;
        end
        n_cmp++;
        if (t >= budget) begin
            n_err++;
            $display("FAIL %s_trmt_wait: no trmt within %0d cycles, required one", name, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp += 7;
        if (grant !== '0)   begin n_err++; $display("FAIL rst_grant: got %b, required 0000", grant); end
        if (req_ack !== '0) begin n_err++; $display("FAIL rst_ack: got %b, required 0000", req_ack); end
        if (trmt !== 1'b0)  begin n_err++; $display("FAIL rst_trmt: got %b, required 0", trmt); end
        if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx_data: got %h, required 00", tx_data); end
        if (busy !== 1'b0)  begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (dut.state_q !== IDLE) begin n_err++; $display("FAIL rst_state: got %0d, required IDLE", dut.state_q); end
        if (dut.rr_ptr_q !== 2'd0) begin n_err++; $display("FAIL rst_rr_ptr: got %0d, required 0", dut.rr_ptr_q); end
        @(posedge clk);
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        int n0 = n_trmt;
        @(posedge clk);
        add_byte(0, 8'h11, 1'b1); add_byte(1, 8'h22, 1'b1);
        add_byte(2, 8'h33, 1'b1); add_byte(3, 8'h44, 1'b1);
        add_byte(0, 8'h55, 1'b1);
        expect_byte(0, 8'h11); expect_byte(1, 8'h22); expect_byte(2, 8'h33);
        expect_byte(3, 8'h44); expect_byte(0, 8'h55);
        wait_drain("rr", 2000);
        n_cmp += 2;
        if (n_trmt - n0 !== 5) begin n_err++; $display("FAIL rr_count: got %0d trmt, required 5", n_trmt - n0); end
        if (dut.rr_ptr_q !== 2'd1) begin n_err++; $display("FAIL rr_ptr: got %0d, required 1", dut.rr_ptr_q); end
    endtask

    task automatic test_single_packet();
        int n0 = n_trmt;
        @(posedge clk);
        add_byte(0, 8'hA5, 1'b0); add_byte(0, 8'h3C, 1'b0); add_byte(0, 8'h0F, 1'b1);
        expect_byte(0, 8'hA5); expect_byte(0, 8'h3C); expect_byte(0, 8'h0F);
        wait_drain("single", 1000);
        @(negedge clk);
        n_cmp += 3;
        if (n_trmt - n0 !== 3) begin n_err++; $display("FAIL single_count: got %0d trmt, required 3", n_trmt - n0); end
        if (grant !== '0) begin n_err++; $display("FAIL single_grant: got %b, required 0000", grant); end
        if (dut.rr_ptr_q !== 2'd1) begin n_err++; $display("FAIL single_rr_ptr: got %0d, required 1", dut.rr_ptr_q); end
    endtask

    task automatic test_stall();
        int t = 0;
        int n1;
        @(posedge clk);
        add_byte(2, 8'h71, 1'b0); add_byte(2, 8'h72, 1'b0); add_byte(2, 8'h73, 1'b1);
        expect_byte(2, 8'h71); expect_byte(2, 8'h72); expect_byte(2, 8'h73); expect_byte(0, 8'h81);
        while (grant !== 4'b0100 && t < 50) begin @(posedge clk); t++; end
        add_byte(0, 8'h81, 1'b1);
        wait_trmt("stall", n_trmt, 100);
        stall[2] = 1'b1;
        n1 = n_trmt;
        repeat (50) @(posedge clk);
        @(negedge clk);
        n_cmp += 2;
        if (grant !== 4'b0100) begin n_err++; $display("FAIL stall_grant: got %b, required 0100", grant); end
        if (n_trmt !== n1) begin n_err++; $display("FAIL stall_trmt: got %0d trmt during stall, required 0", n_trmt - n1); end
        @(posedge clk);
        stall[2] = 1'b0;
        wait_drain("stall", 1000);
    endtask

    task automatic test_max_pkt();
        @(posedge clk);
        for (int i = 0; i < 6; i++) add_byte(1, 8'h90 + 8'(i), i == 5);
        add_byte(3, 8'hC0, 1'b0); add_byte(3, 8'hC1, 1'b1);
        for (int i = 0; i < 4; i++) expect_byte(1, 8'h90 + 8'(i));
        expect_byte(3, 8'hC0); expect_byte(3, 8'hC1);
        expect_byte(1, 8'h94); expect_byte(1, 8'h95);
        wait_drain("maxpkt", 3000);
        n_cmp++;
        if (dut.rr_ptr_q !== 2'd2) begin n_err++; $display("FAIL maxpkt_rr_ptr: got %0d, required 2", dut.rr_ptr_q); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        add_byte(0, 8'hE7, 1'b1);
        expect_byte(0, 8'hE7);
        wait_trmt("rstmid", n_trmt, 100);
        repeat (5) @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp += 4;
        if (grant !== '0)  begin n_err++; $display("FAIL rstmid_grant: got %b, required 0000", grant); end
        if (trmt !== 1'b0) begin n_err++; $display("FAIL rstmid_trmt: got %b, required 0", trmt); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
        if (dut.state_q !== IDLE) begin n_err++; $display("FAIL rstmid_state: got %0d, required IDLE", dut.state_q); end
        @(posedge clk);
        rst = 1'b0;
        @(posedge clk);
        add_byte(3, 8'h5A, 1'b1);
        expect_byte(3, 8'h5A);
        wait_trmt("rstmid_lat", n_trmt, 100);
        n_cmp++;
        if (last_trmt_cyc - req_rise_cyc !== 2) begin
            n_err++;
            $display("FAIL rstmid_latency: got %0d cycles req->trmt, required 2", last_trmt_cyc - req_rise_cyc);
        end
        wait_drain("rstmid", 1000);
    endtask

    task automatic test_gap();
        @(posedge clk);
        add_byte(1, 8'h61, 1'b1); add_byte(2, 8'h62, 1'b1);
        expect_byte(1, 8'h61); expect_byte(2, 8'h62);
        wait_drain("gap", 1000);
        n_cmp++;
        if (last_trmt_gap !== EXP_GAP) begin
            n_err++;
            $display("FAIL gap_len: got %0d cycles tx_done->trmt, required %0d", last_trmt_gap, EXP_GAP);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_packet();
        test_stall();
        test_max_pkt();
        test_reset_mid();
        test_gap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
